// File: rtl/rca_mp_add_seq.sv
// Multi-precision add/subtract sequencer: time-multiplexes one external WIDTH-bit
// ripple-carry adder over WORDS slices, LSW first, with a registered carry chain.
module rca_mp_add_seq #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int W    = WIDTH * WORDS;
  localparam int IDXW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              lastSlice;

  assign lastSlice = (idx_q == IDXW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Subtraction is folded in at accept time: B is stored inverted and the carry seeded with 1.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*WIDTH +: WIDTH] = add_sum;
        carry_d = add_cout;
        if (lastSlice) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[WIDTH-1] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[idx_q*WIDTH +: WIDTH];
      add_b   = b_q[idx_q*WIDTH +: WIDTH];
      add_cin = carry_q;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_rca_mp_add_seq.sv
// Bench for rca_mp_add_seq: external adder model, arithmetic reference model with
// a per-cycle compare process, plus directed vectors with literal expectations.
module tb_rca_mp_add_seq;

  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int W     = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0]     in_a, in_b;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready, out_cout, out_ovf, busy;
  logic [W-1:0]     out_sum;

  int nVec = 0;
  int nMis = 0;
  int cycle = 0;
  int acceptCycle = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] beff;
    logic         c0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t expQ[$];

  rca_mp_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // The external combinational ripple-carry adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result from plain wide arithmetic; overflow from the signed result's range.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [W:0] full;
    logic signed [W+1:0] r;
    e.a    = a;
    e.beff = sub ? ~b : b;
    e.c0   = sub ? 1'b1 : cin;
    if (sub) begin
      full   = {1'b0, a} - {1'b0, b};
      e.cout = (a >= b);
      r = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
    end else begin
      full   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      e.cout = full[W];
      r = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, cin});
    end
    e.sum = full[W-1:0];
    e.ovf = !((r[W+1:W-1] == 3'b000) || (r[W+1:W-1] == 3'b111));
    return e;
  endfunction

  // Carry into slice k is the carry out of the low k slices of A + Beff + c0.
  function automatic logic lowCarry(input exp_t e, input int k);
    logic [W:0] m;
    logic [W:0] s;
    if (k == 0) return e.c0;
    m = ((W+1)'(1) << (k * WIDTH)) - 1;
    s = ({1'b0, e.a} & m) + ({1'b0, e.beff} & m) + (W+1)'(e.c0);
    return s[k*WIDTH];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Track accepted operations and completed handshakes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ.delete();
    end else begin
      cycle++;
      if (out_valid && out_ready && expQ.size() > 0) expQ.pop_front();
      if (in_valid && in_ready) begin
        expQ.push_back(model(in_a, in_b, in_cin, in_sub));
        acceptCycle = cycle;
      end
    end
  end

  // Compare every cycle: handshake flags, adder drive during RUN, result during DONE.
  always @(negedge clk) begin
    logic             expValid;
    logic [WIDTH-1:0] ea, eb;
    logic             ec;
    int               k;
    if (rst_n) begin
      expValid = (expQ.size() > 0) && ((cycle - acceptCycle) >= WORDS);
      check("out_valid", W'(out_valid), W'(expValid));
      check("in_ready", W'(in_ready), W'(expQ.size() == 0));
      check("busy", W'(busy), W'(expQ.size() != 0));
      ea = '0;
      eb = '0;
      ec = 1'b0;
      if (expQ.size() > 0 && !expValid) begin
        k  = cycle - acceptCycle;
        ea = expQ[0].a[k*WIDTH +: WIDTH];
        eb = expQ[0].beff[k*WIDTH +: WIDTH];
        ec = lowCarry(expQ[0], k);
      end
      check("add_a", W'(add_a), W'(ea));
      check("add_b", W'(add_b), W'(eb));
      check("add_cin", W'(add_cin), W'(ec));
      if (expValid) begin
        check("model_sum", out_sum, expQ[0].sum);
        check("model_cout", W'(out_cout), W'(expQ[0].cout));
        check("model_ovf", W'(out_ovf), W'(expQ[0].ovf));
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
    int n;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_cin = 1'($urandom);
    in_sub = 1'($urandom);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", W'(out_valid), W'(1));
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] expSum,
                             input logic expCout, input logic expOvf);
    waitDone();
    check({name, "_sum"}, out_sum, expSum);
    check({name, "_cout"}, W'(out_cout), W'(expCout));
    check({name, "_ovf"}, W'(out_ovf), W'(expOvf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    in_sub = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_sum", out_sum, '0);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_add_a", W'(add_a), W'(0));
    check("rst_add_cin", W'(add_cin), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));

    applyStimulus(64'h0, 64'h0, 1'b0, 1'b0);
    checkOutput("zero", 64'h0, 1'b0, 1'b0);

    applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("ripple_slice1_cin", W'(add_cin), W'(1));
    checkOutput("ripple", 64'h0000_0000_0001_0000, 1'b0, 1'b0);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    checkOutput("allones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    checkOutput("posovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    applyStimulus(64'h5, 64'h7, 1'b1, 1'b1);
    checkOutput("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
    checkOutput("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Backpressure: offer new operands while the result is held in DONE.
    applyStimulus(64'd100, 64'd23, 1'b0, 1'b0);
    waitDone();
    in_a = 64'd10;
    in_b = 64'd20;
    in_cin = 1'b0;
    in_sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_sum", out_sum, 64'd123);
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_out_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", W'(in_ready), W'(1));
    check("bp_idle_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_next", 64'd30, 1'b0, 1'b0);

    // Reset during the slice-2 cycle aborts the operation.
    applyStimulus(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", out_sum, '0);
    check("mid_rst_cout", W'(out_cout), W'(0));
    check("mid_rst_ovf", W'(out_ovf), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_add_a", W'(add_a), W'(0));
    check("mid_rst_add_b", W'(add_b), W'(0));
    check("mid_rst_add_cin", W'(add_cin), W'(0));
    for (int i = 0; i < WORDS + 2; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", W'(out_valid), W'(0));
    end
    rst_n = 1'b1;
    applyStimulus(64'h1, 64'h2, 1'b1, 1'b0);
    checkOutput("post_rst", 64'h4, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/rca_mp_add_seq.md
Name: rca_mp_add_seq

Overview:
- Sequencer that performs WORDS×16-bit multi-precision add/subtract by time-multiplexing one external 16-bit ripple-carry adder.
- Processes one 16-bit slice per cycle, LSW first, chaining the carry through a register.
- Sits between a valid/ready operand source and a valid/ready result sink.
- The adder is combinational and external. This block only drives its A/B/Cin and samples Sum/Cout.

Parameters:
- WIDTH, 16, adder slice width (fixed at 16 for this adder).
- WORDS, 4, number of slices per operand; total operand width W = WIDTH*WORDS; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- add_a  out  WIDTH  to adder A.
- add_b  out  WIDTH  to adder B.
- add_cin  out  1  to adder Cin.
- add_sum  in  WIDTH  from adder Sum.
- add_cout  in  1  from adder Cout.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts result.
- out_sum  out  W  result.
- out_cout  out  1  final carry (sub: 1 = no borrow).
- out_ovf  out  1  signed two's-complement overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: asynchronous, active-low.
  - rst_n=0 forces state IDLE, idx=0, carry=0, operand regs 0.
  - Outputs: out_sum=0, out_cout=0, out_ovf=0, out_valid=0, busy=0, add_a=0, add_b=0, add_cin=0.
  - in_ready=1 once rst_n releases.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a=in_a, b_eff = in_sub ? ~in_b : in_b, carry = in_sub ? 1 : in_cin, idx=0, then go to RUN.
  - Clear out_sum, out_cout, out_ovf on accept.
- RUN:
  - in_ready=0.
  - Adder drive (combinational from registers): add_a=a[idx*16 +:16], add_b=b_eff[idx*16 +:16], add_cin=carry.
  - Each clock: out_sum[idx*16 +:16] <= add_sum; carry <= add_cout.
  - If idx==WORDS-1: capture out_cout <= add_cout and out_ovf <= (a_msb==b_eff_msb)&&(add_sum[15]!=a_msb), then go to DONE. Otherwise idx++.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum, out_cout, out_ovf are held stable until out_ready.
  - On out_ready go to IDLE; out_valid drops the next cycle.
- Adder drive outside RUN: add_a/add_b/add_cin=0.
- Latency: accept edge at cycle k → out_valid high from cycle k+WORDS.
  - Minimum throughput: one operation per WORDS+2 cycles.
  - No accept is allowed in DONE, even when out_ready=1 in the same cycle.
- in_valid is ignored outside IDLE. Operand inputs may change freely after the accept edge.
- Carry chain is strictly registered between slices. No combinational path exists from add_cout to add_cin.
- Width rules:
  - Results wrap modulo 2^W; out_cout carries bit W.
  - Subtraction ignores in_cin.
  - idx is a counter of width clog2(WORDS) and never exceeds WORDS-1.
- Reset mid-operation (RUN or DONE): abort immediately, with the reset values above. A partial result is never presented.
- out_ready while not DONE: no effect.

Test Plan:
- Zero add: A=0, B=0, cin=0, add → out_sum=0, cout=0, ovf=0, out_valid exactly 4 cycles after accept; add_a/add_b equal slices 0..3 on consecutive RUN cycles.
- Carry ripple across slices: A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → out_sum=0x0000_0000_0001_0000, cout=0; add_cin=1 observed on slice-1 cycle.
- Max overflow: A=B=0xFFFF_FFFF_FFFF_FFFF, cin=1 → out_sum=0xFFFF_FFFF_FFFF_FFFF, cout=1, ovf=0; A=0x7FFF_FFFF_FFFF_FFFF, B=1 → out_sum=0x8000_0000_0000_0000, ovf=1.
- Subtract: 5-7 (cin=1 applied, must be ignored) → out_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; 0x8000_0000_0000_0000-1 → 0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands → result stable, in_ready=0, no accept; out_ready=1 → IDLE next cycle, then new operands accepted.
- Reset mid-RUN: pull rst_n low on slice-2 cycle → all outputs 0 asynchronously, out_valid never pulses; after release, A=1, B=2, cin=1 → out_sum=4.
